// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD sequential multiplier: operand geometry,
// FSM state encoding and a BCD digit-validity helper.
package bcd_pkg;

  localparam int NDIG  = 7;
  localparam int DIGW  = 4;
  localparam int WORDW = NDIG * DIGW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ADD   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // A BCD digit is legal only in the range 0..9.
  function automatic logic digit_ok(input logic [DIGW-1:0] d);
    return (d <= 4'd9);
  endfunction

  // True when every packed digit of a word is a legal BCD digit.
  function automatic logic word_ok(input logic [WORDW-1:0] w);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      ok = ok & digit_ok(w[i*DIGW +: DIGW]);
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_adder.sv
// Combinational 7-digit packed-BCD adder with ripple decimal carry.
// Mr holds the low 7 digits of M1+M2; carry is the decimal carry out of
// the most significant digit.
module BCD_adder
  import bcd_pkg::*;
(
  input  logic [WORDW-1:0] M1,
  input  logic [WORDW-1:0] M2,
  output logic [WORDW-1:0] Mr,
  output logic             carry
);

  // Digit-serial ripple: binary digit sum, corrected by +6 when above 9.
  always_comb begin : add_chain
    logic [4:0] s;
    logic       c;
    c  = 1'b0;
    s  = '0;
    Mr = '0;
    for (int i = 0; i < NDIG; i++) begin
      s = {1'b0, M1[i*DIGW +: DIGW]} + {1'b0, M2[i*DIGW +: DIGW]} + {4'b0000, c};
      if (s > 5'd9) begin
        s = s + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      Mr[i*DIGW +: DIGW] = s[3:0];
    end
    carry = c;
  end

endmodule

// File: rtl/bcd_seq_mult.sv
// Sequential packed-BCD multiplier, MSD-first shift-and-add.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; latches operands and validates digits
//   SHIFT | acc = acc*10 (one digit shift), load repeat count from b
//   ADD   | acc = acc + a, once per cycle, count times
//   DONE  | publish product/overflow/err with a one-cycle done pulse
//
// Latency from the start-sampling edge to done is 8 + (sum of b digits),
// or 1 cycle when an operand digit is illegal.
module bcd_seq_mult
  import bcd_pkg::*;
#(
  parameter int NDIG = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NDIG*DIGW-1:0] a,
  input  logic [NDIG*DIGW-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [NDIG*DIGW-1:0] product,
  output logic                 overflow,
  output logic                 err
);

  localparam int W = NDIG * DIGW;

  state_t           state;
  logic [W-1:0]     a_lat;
  logic [W-1:0]     b_lat;
  logic [W-1:0]     acc;
  logic             ovf;
  logic             err_int;
  logic [2:0]       idx;
  logic [DIGW-1:0]  cnt;

  logic [W-1:0]     sum;
  logic             sum_carry;
  logic [DIGW-1:0]  bdig;
  logic             operands_ok;

  BCD_adder u_adder (
    .M1    (acc),
    .M2    (a_lat),
    .Mr    (sum),
    .carry (sum_carry)
  );

  assign bdig        = b_lat[{idx, 2'b00} +: DIGW];
  assign operands_ok = word_ok(a) && word_ok(b);

  // Main FSM: operand latch, shift/add datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
      overflow <= 1'b0;
      err      <= 1'b0;
      a_lat    <= '0;
      b_lat    <= '0;
      acc      <= '0;
      ovf      <= 1'b0;
      err_int  <= 1'b0;
      idx      <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A start coinciding with the done pulse is held off one cycle.
          if (start && !done) begin
            a_lat   <= a;
            b_lat   <= b;
            acc     <= '0;
            ovf     <= 1'b0;
            err_int <= !operands_ok;
            idx     <= 3'(NDIG - 1);
            busy    <= 1'b1;
            state   <= operands_ok ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          acc <= {acc[W-DIGW-1:0], 4'h0};
          if (acc[W-1 -: DIGW] != '0) ovf <= 1'b1;
          cnt <= bdig;
          if (bdig != '0) begin
            state <= ADD;
          end else if (idx == '0) begin
            state <= DONE;
          end else begin
            idx   <= idx - 1'b1;
            state <= SHIFT;
          end
        end
        ADD: begin
          acc <= sum;
          if (sum_carry) ovf <= 1'b1;
          cnt <= cnt - 1'b1;
          if (cnt == 4'd1) begin
            if (idx == '0) begin
              state <= DONE;
            end else begin
              idx   <= idx - 1'b1;
              state <= SHIFT;
            end
          end
        end
        DONE: begin
          done     <= 1'b1;
          product  <= acc;
          overflow <= ovf;
          err      <= err_int;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_mult.sv
// Self-checking bench for bcd_seq_mult: directed corner cases plus random
// operands checked against an integer-arithmetic reference model.
module tb_bcd_seq_mult;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [27:0] a, b;
  logic        busy, done, overflow, err;
  logic [27:0] product;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          t0       = 0;
  logic [27:0] last_prod;

  bcd_seq_mult #(.NDIG(7)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .overflow (overflow),
    .err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic longint bcd2int(input logic [27:0] w);
    longint v;
    v = 0;
    for (int i = 6; i >= 0; i--) v = v * 10 + longint'(w[i*4 +: 4]);
    return v;
  endfunction

  function automatic logic [27:0] int2bcd(input longint v);
    logic [27:0] r;
    longint      t;
    t = v;
    r = '0;
    for (int i = 0; i < 7; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit legal(input logic [27:0] w);
    bit ok;
    ok = 1;
    for (int i = 0; i < 7; i++) if (w[i*4 +: 4] > 4'd9) ok = 0;
    return ok;
  endfunction

  function automatic int digit_sum(input logic [27:0] w);
    int s;
    s = 0;
    for (int i = 0; i < 7; i++) s += int'(w[i*4 +: 4]);
    return s;
  endfunction

  function automatic logic [27:0] rand_bcd(input int nd);
    logic [27:0] r;
    r = '0;
    for (int i = 0; i < nd; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [27:0] x, input logic [27:0] y);
    @(negedge clk);
    a     = x;
    b     = y;
    start = 1'b1;
    t0    = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    chk("hold_product", {4'b0, product}, {4'b0, last_prod});
  endtask

  task automatic finish_op(input logic [27:0] x, input logic [27:0] y,
                           input bit chain, input logic [27:0] ca, input logic [27:0] cb);
    int          k;
    int          exp_lat;
    logic [27:0] exp_p;
    bit          exp_o, exp_e;
    longint      full;
    if (legal(x) && legal(y)) begin
      full    = bcd2int(x) * bcd2int(y);
      exp_p   = int2bcd(full % 10000000);
      exp_o   = (full > 9999999);
      exp_e   = 0;
      exp_lat = 8 + digit_sum(y);
    end else begin
      exp_p   = '0;
      exp_o   = 0;
      exp_e   = 1;
      exp_lat = 1;
    end
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 200);
    chk("done_seen", {31'b0, done}, 32'd1);
    chk("latency", cyc - t0, exp_lat);
    chk("product", {4'b0, product}, {4'b0, exp_p});
    chk("overflow", {31'b0, overflow}, {31'b0, exp_o});
    chk("err", {31'b0, err}, {31'b0, exp_e});
    chk("busy_at_done", {31'b0, busy}, 32'd0);
    if (chain) begin
      a     = ca;
      b     = cb;
      start = 1'b1;
    end
    @(negedge clk);
    chk("done_pulse_width", {31'b0, done}, 32'd0);
    chk("start_at_done_ignored", {31'b0, busy}, 32'd0);
    last_prod = exp_p;
  endtask

  task automatic run(input logic [27:0] x, input logic [27:0] y);
    start_op(x, y);
    finish_op(x, y, 0, '0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [27:0] x, y;
    rst_n     = 1'b0;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    last_prod = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_product", {4'b0, product}, 32'd0);
    chk("reset_overflow", {31'b0, overflow}, 32'd0);
    chk("reset_err", {31'b0, err}, 32'd0);
    rst_n = 1'b1;

    // 12 * 34
    run(28'h0000012, 28'h0000034);
    chk("r029_product", {4'b0, product}, 32'h0000408);

    // adder-carry overflow
    run(28'h9999999, 28'h0000002);
    chk("r030_product", {4'b0, product}, 32'h9999998);
    chk("r030_overflow", {31'b0, overflow}, 32'd1);

    // shift-out overflow
    run(28'h1000000, 28'h0000010);
    chk("r031_product", {4'b0, product}, 32'h0000000);
    chk("r031_overflow", {31'b0, overflow}, 32'd1);

    // illegal digit
    run(28'h00000A5, 28'h1234567);
    chk("r032_err", {31'b0, err}, 32'd1);

    // start while busy is ignored
    start_op(28'h0000012, 28'h0000034);
    repeat (2) @(negedge clk);
    a     = 28'h5;
    b     = 28'h5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_op(28'h0000012, 28'h0000034, 0, '0, '0);

    // start held through the done cycle is taken on the following IDLE cycle
    start_op(28'h0000003, 28'h0000021);
    finish_op(28'h0000003, 28'h0000021, 1, 28'h0000007, 28'h0000003);
    t0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    chk("chained_start_busy", {31'b0, busy}, 32'd1);
    finish_op(28'h0000007, 28'h0000003, 0, '0, '0);

    // reset mid-operation
    start_op(28'h0000012, 28'h0000034);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_product", {4'b0, product}, 32'd0);
    chk("midrst_overflow", {31'b0, overflow}, 32'd0);
    chk("midrst_err", {31'b0, err}, 32'd0);
    last_prod = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_done", {31'b0, done}, 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("aborted_no_done", {31'b0, done}, 32'd0);
    end
    run(28'h0000007, 28'h0000003);
    chk("r034_product", {4'b0, product}, 32'h0000021);

    // random operands against the integer model
    for (int n = 0; n < 24; n++) begin
      x = rand_bcd($urandom_range(1, 7));
      y = rand_bcd($urandom_range(1, 7));
      if ($urandom_range(0, 7) == 0) x[$urandom_range(0, 6)*4 +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 7) == 0) y[$urandom_range(0, 6)*4 +: 4] = 4'($urandom_range(10, 15));
      run(x, y);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
